// File: rtl/kbd_pkg.sv
// Shared scan-code constants, state and key-index types for the PS/2 arrow-key decoder.
package kbd_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_PAUSE = 8'hE1;
    localparam logic [7:0] SC_BAT   = 8'hAA;
    localparam logic [7:0] SC_ERR0  = 8'h00;
    localparam logic [7:0] SC_ERRF  = 8'hFF;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EXT     = 3'd1,
        BRK     = 3'd2,
        EXT_BRK = 3'd3,
        PAUSE   = 3'd4
    } kbd_state_t;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } kbd_key_t;

    // One-hot key mask for an arrow code, zero for anything else.
    function automatic logic [3:0] key_mask(input logic [7:0] code);
        case (code)
            SC_UP:    key_mask = 4'b0001;
            SC_DOWN:  key_mask = 4'b0010;
            SC_LEFT:  key_mask = 4'b0100;
            SC_RIGHT: key_mask = 4'b1000;
            default:  key_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/kbd_arrow_keys_if.sv
// Byte-in / key-level-out bundle between the PS/2 byte receiver, the decoder and the movement block.
interface kbd_arrow_keys_if;
    logic       din_new;
    logic [7:0] din;
    logic       up_key_pressed;
    logic       down_key_pressed;
    logic       left_key_pressed;
    logic       right_key_pressed;
    logic       key_event;
    logic       seq_error;

    modport master (
        output din_new, din,
        input  up_key_pressed, down_key_pressed, left_key_pressed, right_key_pressed,
        input  key_event, seq_error
    );

    modport slave (
        input  din_new, din,
        output up_key_pressed, down_key_pressed, left_key_pressed, right_key_pressed,
        output key_event, seq_error
    );
endinterface

// File: rtl/kbd_seq_timer.sv
// Saturating inter-byte timer; expired is high while run is set and the count sits at its last value.
module kbd_seq_timer #(
    parameter int TIMEOUT_CYCLES = 1_500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYCLES);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);
    localparam logic [W-1:0] ONE  = W'(1);

    logic [W-1:0] count_r;

    // Count while a sequence is open, hold at zero otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= '0;
        end else if (clear || !run) begin
            count_r <= '0;
        end else if (count_r != LAST) begin
            count_r <= count_r + ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = run && (count_r == LAST);
endmodule

// File: rtl/kbd_arrow_keys.sv
// PS/2 set-2 scan-code stream to held arrow-key levels with make/break, E0, Pause skip and timeout recovery.
// Optional build macro KBD_KEYPAD_ALIAS_EN aliases the non-extended keypad 8/2/4/6 codes to the arrows.
module kbd_arrow_keys
    import kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_500_000,
    parameter int PAUSE_LEN      = 8
) (
    input  logic           clk,
    input  logic           reset,
    kbd_arrow_keys_if.slave bus
);
    localparam int PW = $clog2(PAUSE_LEN + 1);
    localparam logic [PW-1:0] PAUSE_LAST = PW'(PAUSE_LEN - 1);
    localparam logic [PW-1:0] PAUSE_ONE  = PW'(1);

    kbd_state_t    state_r, state_s, cur_s;
    logic [PW-1:0] pause_r, pause_s;
    logic [3:0]    arrow_r, arrow_s;
    logic [3:0]    keypad_r, keypad_s;
    logic [3:0]    keys_r, keys_s, mask_s;
    logic          key_event_r, seq_error_r, err_s, expired_s;

    kbd_seq_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (bus.din_new),
        .run     (state_r != IDLE),
        .expired (expired_s)
    );

    // Next-state decode; a timeout in the same cycle drops to IDLE before the byte is interpreted.
    always_comb begin
        cur_s    = expired_s ? IDLE : state_r;
        pause_s  = (cur_s == PAUSE) ? pause_r : '0;
        arrow_s  = arrow_r;
        keypad_s = keypad_r;
        err_s    = expired_s;
        mask_s   = key_mask(bus.din);
        if (bus.din_new) begin
            state_s = IDLE;
            if (bus.din == SC_ERR0 || bus.din == SC_ERRF) begin
                arrow_s  = 4'b0000;
                keypad_s = 4'b0000;
                err_s    = 1'b1;
            end else begin
                case (cur_s)
                    IDLE: begin
                        case (bus.din)
                            SC_EXT:   state_s = EXT;
                            SC_BRK:   state_s = BRK;
                            SC_PAUSE: begin
                                state_s = PAUSE;
                                pause_s = PAUSE_ONE;
                            end
                            SC_BAT: begin
                                arrow_s  = 4'b0000;
                                keypad_s = 4'b0000;
                            end
`ifdef KBD_KEYPAD_ALIAS_EN
                            default:  keypad_s = keypad_r | mask_s;
`else
                            default:  state_s = IDLE;
`endif
                        endcase
                    end
                    EXT: begin
                        if (bus.din == SC_BRK) begin
                            state_s = EXT_BRK;
                        end else begin
                            arrow_s = arrow_r | mask_s;
                        end
                    end
                    EXT_BRK: arrow_s = arrow_r & ~mask_s;
`ifdef KBD_KEYPAD_ALIAS_EN
                    BRK:     keypad_s = keypad_r & ~mask_s;
`else
                    BRK:     state_s = IDLE;
`endif
                    PAUSE: begin
                        if (pause_r == PAUSE_LAST) begin
                            pause_s = '0;
                        end else begin
                            state_s = PAUSE;
                            pause_s = pause_r + PAUSE_ONE;
                        end
                    end
                    default: state_s = IDLE;
                endcase
            end
        end else begin
            state_s = cur_s;
        end
`ifdef KBD_KEYPAD_ALIAS_EN
        keys_s = arrow_s | keypad_s;
`else
        keypad_s = 4'b0000;
        keys_s   = arrow_s;
`endif
    end

    // State, held-key sources and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            pause_r     <= '0;
            arrow_r     <= 4'b0000;
            keypad_r    <= 4'b0000;
            keys_r      <= 4'b0000;
            key_event_r <= 1'b0;
            seq_error_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            pause_r     <= pause_s;
            arrow_r     <= arrow_s;
            keypad_r    <= keypad_s;
            keys_r      <= keys_s;
            key_event_r <= |(keys_s ^ keys_r);
            seq_error_r <= err_s;
        end
    end

    assign bus.up_key_pressed    = keys_r[UP];
    assign bus.down_key_pressed  = keys_r[DOWN];
    assign bus.left_key_pressed  = keys_r[LEFT];
    assign bus.right_key_pressed = keys_r[RIGHT];
    assign bus.key_event         = key_event_r;
    assign bus.seq_error         = seq_error_r;
endmodule

// File: tb/tb_kbd_arrow_keys.sv
// Scoreboard bench for kbd_arrow_keys (TIMEOUT_CYCLES=20); key vectors are {right,left,down,up}.
module tb_kbd_arrow_keys;
`ifdef KBD_KEYPAD_ALIAS_EN
    localparam bit ALIAS = 1'b1;
`else
    localparam bit ALIAS = 1'b0;
`endif

    typedef struct {
        string      tag;
        logic [3:0] keys;
        logic       evt;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    kbd_arrow_keys_if bus();

    kbd_arrow_keys #(.TIMEOUT_CYCLES(20), .PAUSE_LEN(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] keys_now();
        return {bus.right_key_pressed, bus.left_key_pressed, bus.down_key_pressed, bus.up_key_pressed};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one byte strobe; the expected result is queued, then popped once the DUT has registered it.
    task automatic send(input logic [7:0] b, input logic [3:0] k, input logic e, input logic r, input string tag);
        exp_t x;
        @(negedge clk);
        bus.din_new = 1'b1;
        bus.din     = b;
        sb.push_back('{tag, k, e, r});
        @(negedge clk);
        bus.din_new = 1'b0;
        x = sb.pop_front();
        chk({x.tag, "_keys"}, 32'(keys_now()), 32'(x.keys));
        chk({x.tag, "_evt"},  32'(bus.key_event), 32'(x.evt));
        chk({x.tag, "_err"},  32'(bus.seq_error), 32'(x.err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        bus.din_new = 1'b0;
        bus.din     = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_keys", 32'(keys_now()), 32'h0);
        chk("rst_evt",  32'(bus.key_event), 32'h0);
        chk("rst_err",  32'(bus.seq_error), 32'h0);

        // Up make / break
        send(8'hE0, 4'b0000, 1'b0, 1'b0, "up_e0");
        send(8'h75, 4'b0001, 1'b1, 1'b0, "up_mk");
        send(8'hE0, 4'b0001, 1'b0, 1'b0, "up_b0");
        send(8'hF0, 4'b0001, 1'b0, 1'b0, "up_b1");
        send(8'h75, 4'b0000, 1'b1, 1'b0, "up_brk");

        // Left + right, typematic repeats of right
        send(8'hE0, 4'b0000, 1'b0, 1'b0, "lf_e0");
        send(8'h6B, 4'b0100, 1'b1, 1'b0, "lf_mk");
        send(8'hE0, 4'b0100, 1'b0, 1'b0, "rt_e0");
        send(8'h74, 4'b1100, 1'b1, 1'b0, "rt_mk");
        for (int i = 0; i < 3; i++) begin
            send(8'hE0, 4'b1100, 1'b0, 1'b0, "rep_e0");
            send(8'h74, 4'b1100, 1'b0, 1'b0, "rep_mk");
        end
        send(8'hE0, 4'b1100, 1'b0, 1'b0, "lfb_e0");
        send(8'hF0, 4'b1100, 1'b0, 1'b0, "lfb_f0");
        send(8'h6B, 4'b1000, 1'b1, 1'b0, "lf_brk");
        send(8'hE0, 4'b1000, 1'b0, 1'b0, "rtb_e0");
        send(8'hF0, 4'b1000, 1'b0, 1'b0, "rtb_f0");
        send(8'h74, 4'b0000, 1'b1, 1'b0, "rt_brk");
        // Break of a key not held
        send(8'hE0, 4'b0000, 1'b0, 1'b0, "nh_e0");
        send(8'hF0, 4'b0000, 1'b0, 1'b0, "nh_f0");
        send(8'h6B, 4'b0000, 1'b0, 1'b0, "nh_brk");

        // Lone E0 times out 20 cycles later
        send(8'hE0, 4'b0000, 1'b0, 1'b0, "to_e0");
        seen = 0;
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            if (bus.seq_error && seen == 0) seen = i;
        end
        chk("to_cycle", 32'(seen), 32'd20);
        chk("to_keys", 32'(keys_now()), 32'h0);
        send(8'h72, ALIAS ? 4'b0010 : 4'b0000, ALIAS, 1'b0, "to_72");
        if (ALIAS) begin
            send(8'hF0, 4'b0010, 1'b0, 1'b0, "kp_f0");
            send(8'h72, 4'b0000, 1'b1, 1'b0, "kp_brk");
        end

        // Byte arriving exactly at expiry is decoded from IDLE
        send(8'hE0, 4'b0000, 1'b0, 1'b0, "tx_e0");
        repeat (18) @(negedge clk);
        send(8'h75, ALIAS ? 4'b0001 : 4'b0000, ALIAS, 1'b1, "tx_75");
        if (ALIAS) begin
            send(8'hF0, 4'b0001, 1'b0, 1'b0, "tx_f0");
            send(8'h75, 4'b0000, 1'b1, 1'b0, "tx_brk");
        end

        // Pause sequence does not disturb a held key
        send(8'hE0, 4'b0000, 1'b0, 1'b0, "dn_e0");
        send(8'h72, 4'b0010, 1'b1, 1'b0, "dn_mk");
        send(8'hE1, 4'b0010, 1'b0, 1'b0, "pz0");
        send(8'h14, 4'b0010, 1'b0, 1'b0, "pz1");
        send(8'h77, 4'b0010, 1'b0, 1'b0, "pz2");
        send(8'hE1, 4'b0010, 1'b0, 1'b0, "pz3");
        send(8'hF0, 4'b0010, 1'b0, 1'b0, "pz4");
        send(8'h14, 4'b0010, 1'b0, 1'b0, "pz5");
        send(8'hF0, 4'b0010, 1'b0, 1'b0, "pz6");
        send(8'h77, 4'b0010, 1'b0, 1'b0, "pz7");
        send(8'hE0, 4'b0010, 1'b0, 1'b0, "dnb_e0");
        send(8'hF0, 4'b0010, 1'b0, 1'b0, "dnb_f0");
        send(8'h72, 4'b0000, 1'b1, 1'b0, "dn_brk");

        // Error byte FF clears everything
        send(8'hE0, 4'b0000, 1'b0, 1'b0, "ff_e0a");
        send(8'h75, 4'b0001, 1'b1, 1'b0, "ff_up");
        send(8'hE0, 4'b0001, 1'b0, 1'b0, "ff_e0b");
        send(8'h74, 4'b1001, 1'b1, 1'b0, "ff_rt");
        send(8'hFF, 4'b0000, 1'b1, 1'b1, "ff_err");

        // Error byte 00 mid-sequence
        send(8'hE0, 4'b0000, 1'b0, 1'b0, "z_e0a");
        send(8'h72, 4'b0010, 1'b1, 1'b0, "z_dn");
        send(8'hE0, 4'b0010, 1'b0, 1'b0, "z_e0b");
        send(8'h00, 4'b0000, 1'b1, 1'b1, "z_err");

        // Self-test pass clears held keys
        send(8'hE0, 4'b0000, 1'b0, 1'b0, "bat_e0");
        send(8'h6B, 4'b0100, 1'b1, 1'b0, "bat_lf");
        send(8'hAA, 4'b0000, 1'b1, 1'b0, "bat_aa");

        // Reset between E0 and 75
        send(8'hE0, 4'b0000, 1'b0, 1'b0, "mr_e0");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mr_keys", 32'(keys_now()), 32'h0);
        send(8'h75, ALIAS ? 4'b0001 : 4'b0000, ALIAS, 1'b0, "mr_75");

        // Keypad alias versus arrow source
        if (ALIAS) begin
            send(8'hE0, 4'b0001, 1'b0, 1'b0, "al_e0");
            send(8'h75, 4'b0001, 1'b0, 1'b0, "al_mk");
            send(8'hF0, 4'b0001, 1'b0, 1'b0, "al_f0");
            send(8'h75, 4'b0001, 1'b0, 1'b0, "al_kpb");
            send(8'hE0, 4'b0001, 1'b0, 1'b0, "al_be0");
            send(8'hF0, 4'b0001, 1'b0, 1'b0, "al_bf0");
            send(8'h75, 4'b0000, 1'b1, 1'b0, "al_brk");
        end else begin
            send(8'h74, 4'b0000, 1'b0, 1'b0, "na_74");
        end

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
